// File: rtl/regfile_mp.sv
// Multi-port register file with a hard-wired zero entry, selectable async/registered
// read, and a clear sequencer that zeroes one entry per cycle after reset or on request.
module regfile_mp #(
  parameter int AWL      = 5,
  parameter int DWL      = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int MODE     = 0,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [NWR-1:0]       wen,
  input  logic [NWR*AWL-1:0]   WA,
  input  logic [NWR*DWL-1:0]   WD,
  input  logic [NRD*AWL-1:0]   RA,
  output logic [NRD*DWL-1:0]   RD,
  output logic                 ready
);

  localparam int DEPTH = 2 ** AWL;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state;
  logic [AWL-1:0]   cnt;
  logic [DWL-1:0]   mem [DEPTH];
  logic [NWR-1:0]   wr_ok;

  // A port write takes effect only in RUN and never to the zero register.
  always_comb begin
    wr_ok = '0;
    for (int unsigned i = 0; i < NWR; i++) begin
      wr_ok[i] = (state == RUN) && wen[i] &&
                 !((ZERO_REG != 0) && (WA[i*AWL +: AWL] == '0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (cnt == '1) begin
            state <= RUN;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (clr) begin
            state <= CLEAR;
            ready <= 1'b0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes it. Later ports overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else begin
      for (int unsigned i = 0; i < NWR; i++) begin
        if (wr_ok[i]) begin
          mem[WA[i*AWL +: AWL]] <= WD[i*DWL +: DWL];
        end
      end
    end
  end

  if (MODE == 1) begin : g_reg
    logic [NRD*DWL-1:0] rd_next;
    logic [NRD*DWL-1:0] rd_q;

    // Next read value is the entry content after this edge's writes, so the
    // highest-index matching port is forwarded over the array.
    always_comb begin
      logic [AWL-1:0] addr;
      rd_next = '0;
      addr    = '0;
      for (int unsigned j = 0; j < NRD; j++) begin
        addr = RA[j*AWL +: AWL];
        if ((state == RUN) && !clr && !((ZERO_REG != 0) && (addr == '0))) begin
          rd_next[j*DWL +: DWL] = mem[addr];
          for (int unsigned i = 0; i < NWR; i++) begin
            if (wr_ok[i] && (WA[i*AWL +: AWL] == addr)) begin
              rd_next[j*DWL +: DWL] = WD[i*DWL +: DWL];
            end
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_next;
      end
    end

    assign RD = rd_q;
  end else begin : g_async
    logic [NRD*DWL-1:0] rd_comb;

    always_comb begin
      logic [AWL-1:0] addr;
      rd_comb = '0;
      addr    = '0;
      for (int unsigned j = 0; j < NRD; j++) begin
        addr = RA[j*AWL +: AWL];
        if ((state == RUN) && !((ZERO_REG != 0) && (addr == '0))) begin
          rd_comb[j*DWL +: DWL] = mem[addr];
        end
      end
    end

    assign RD = rd_comb;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Drives an async-read and a registered-read instance with identical stimulus and
// compares both against an array-based model of the register file.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  wen = '0;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic [4:0]  ra [2];
  logic [9:0]  wa_bus, ra_bus;
  logic [63:0] wd_bus, rd_a, rd_b;
  logic        ready_a, ready_b;

  assign wa_bus = {wa[1], wa[0]};
  assign wd_bus = {wd[1], wd[0]};
  assign ra_bus = {ra[1], ra[0]};

  always #5 clk = ~clk;

  regfile_mp #(.AWL(5), .DWL(32), .NRD(2), .NWR(2), .MODE(0), .ZERO_REG(1)) u_async (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen), .WA(wa_bus), .WD(wd_bus),
    .RA(ra_bus), .RD(rd_a), .ready(ready_a));

  regfile_mp #(.AWL(5), .DWL(32), .NRD(2), .NWR(2), .MODE(1), .ZERO_REG(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen), .WA(wa_bus), .WD(wd_bus),
    .RA(ra_bus), .RD(rd_b), .ready(ready_b));

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  logic [31:0] mm [32];
  bit          run = 1'b0;
  int          sweep = 0;
  logic [31:0] last_b [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mexp(input logic [4:0] a);
    return (run && a != 5'd0) ? mm[a] : 32'd0;
  endfunction

  task automatic model_reset();
    run = 1'b0;
    sweep = 0;
    last_b[0] = '0;
    last_b[1] = '0;
  endtask

  // One rising edge of the reference: count sweep cycles, or apply writes in port order.
  task automatic model_edge();
    if (!run) begin
      sweep++;
      if (sweep == 32) begin
        run = 1'b1;
        for (int k = 0; k < 32; k++) mm[k] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++)
        if (wen[i] && wa[i] != 5'd0) mm[wa[i]] = wd[i];
      if (clr) begin
        run = 1'b0;
        sweep = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] e;
    check("ready_m0", {31'd0, ready_a}, {31'd0, run});
    check("ready_m1", {31'd0, ready_b}, {31'd0, run});
    for (int j = 0; j < 2; j++) begin
      e = mexp(ra[j]);
      check($sformatf("rd%0d_m0", j), rd_a[j*32 +: 32], e);
      check($sformatf("rd%0d_m1", j), rd_b[j*32 +: 32], e);
      last_b[j] = e;
    end
  endtask

  // Drive at a falling edge, check pre-edge behaviour, then check after the rising edge.
  task automatic cycle(input logic c, input logic [1:0] we, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [4:0] r0, input logic [4:0] r1);
    clr = c; wen = we;
    wa[0] = a0; wa[1] = a1; wd[0] = d0; wd[1] = d1; ra[0] = r0; ra[1] = r1;
    #1;
    for (int j = 0; j < 2; j++) begin
      check($sformatf("pre_rd%0d_m0", j), rd_a[j*32 +: 32], mexp(ra[j]));
      check($sformatf("hold_rd%0d_m1", j), rd_b[j*32 +: 32], last_b[j]);
    end
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset_check();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_ready_m0", {31'd0, ready_a}, 32'd0);
    check("rst_ready_m1", {31'd0, ready_b}, 32'd0);
    check("rst_rd_m0", rd_a[31:0], 32'd0);
    check("rst_rd_m1", rd_b[31:0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] a0, a1, r0, r1;
    int guard;
    wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0; ra[0] = '0; ra[1] = '0;
    model_reset();
    for (int k = 0; k < 32; k++) mm[k] = '0;

    #1;
    check("reset_ready_m0", {31'd0, ready_a}, 32'd0);
    check("reset_ready_m1", {31'd0, ready_b}, 32'd0);
    check("reset_rd_m1", rd_b[31:0], 32'd0);
    check("reset_rd_m0", rd_a[31:0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 1; k <= 32; k++) begin
      cycle(1'b0, 2'b01, 5'd3, 5'd0, 32'hDEAD, 32'd0, 5'd3, 5'd0);
      check("sweep_ready", {31'd0, ready_a}, (k == 32) ? 32'd1 : 32'd0);
    end
    cycle(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd0);
    check("dropped_wr", rd_a[31:0], 32'd0);

    cycle(1'b0, 2'b01, 5'd5, 5'd0, 32'h1234, 32'd0, 5'd5, 5'd0);
    check("basic_rd0_m0", rd_a[31:0], 32'h1234);
    check("basic_rd0_m1", rd_b[31:0], 32'h1234);
    check("basic_rd1_zero", rd_a[63:32], 32'd0);
    cycle(1'b0, 2'b01, 5'd0, 5'd0, 32'hFFFF, 32'd0, 5'd5, 5'd0);
    check("zero_wr_rd1_m0", rd_a[63:32], 32'd0);
    check("zero_wr_rd1_m1", rd_b[63:32], 32'd0);

    cycle(1'b0, 2'b11, 5'd7, 5'd7, 32'hAAAA, 32'hBBBB, 5'd7, 5'd0);
    check("conflict_m0", rd_a[31:0], 32'hBBBB);
    check("conflict_m1", rd_b[31:0], 32'hBBBB);

    cycle(1'b0, 2'b01, 5'd9, 5'd0, 32'h11, 32'd0, 5'd9, 5'd0);
    check("bypass_old", rd_b[31:0], 32'h11);
    cycle(1'b0, 2'b01, 5'd9, 5'd0, 32'h55, 32'd0, 5'd9, 5'd0);
    check("bypass_new", rd_b[31:0], 32'h55);

    for (int a = 1; a < 32; a++)
      cycle(1'b0, 2'b01, 5'(a), 5'd0, 32'h100 + 32'(a), 32'd0, 5'(a), 5'd0);
    cycle(1'b1, 2'b01, 5'd4, 5'd0, 32'h4444, 32'd0, 5'd4, 5'd0);
    check("clr_ready", {31'd0, ready_a}, 32'd0);
    for (int k = 1; k <= 32; k++) begin
      cycle(1'b0, 2'b11, 5'd6, 5'd8, 32'h66, 32'h88, 5'd6, 5'd8);
      check("clr_sweep_ready", {31'd0, ready_b}, (k == 32) ? 32'd1 : 32'd0);
    end
    for (int a = 0; a < 32; a++) begin
      cycle(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'(a), 5'(31 - a));
      check("cleared_m0", rd_a[31:0], 32'd0);
      check("cleared_m1", rd_b[63:32], 32'd0);
    end

    cycle(1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd2);
    for (int k = 0; k < 10; k++)
      cycle(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd2);
    async_reset_check();
    for (int k = 1; k <= 32; k++) begin
      cycle(1'b0, 2'b01, 5'd2, 5'd0, 32'h22, 32'd0, 5'd2, 5'd1);
      check("resweep_ready", {31'd0, ready_a}, (k == 32) ? 32'd1 : 32'd0);
    end

    for (int n = 0; n < 700; n++) begin
      a0 = 5'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom);
      r0 = ($urandom_range(0, 1) == 0) ? a0 : 5'($urandom);
      r1 = ($urandom_range(0, 1) == 0) ? a1 : 5'($urandom);
      cycle(($urandom_range(0, 79) == 0), 2'($urandom), a0, a1, $urandom, $urandom, r0, r1);
    end

    guard = 0;
    while (!run && guard < 40) begin
      cycle(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      guard++;
    end
    check("run_before_midrun_rst", {31'd0, ready_a}, 32'd1);
    cycle(1'b0, 2'b01, 5'd6, 5'd0, 32'hCAFE, 32'd0, 5'd6, 5'd0);
    check("midrun_data", rd_b[31:0], 32'hCAFE);
    async_reset_check();
    for (int k = 1; k <= 32; k++)
      cycle(1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd6, 5'd0);
    check("midrun_cleared", rd_a[31:0], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
